// File: rtl/out_serializer.sv
// out_serializer: start/stop framed parallel-to-serial transmitter, LSB first.
// Ports: clk, clear (sync, active-high), load/data/ready handshake, tx, busy, done.
// Optional even-parity slot before STOP when OUT_SERIALIZER_PARITY_EN is defined.
module out_serializer #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int BCW = $clog2(WIDTH) + 1;
  localparam int BDW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(WIDTH - 1);
  localparam logic [BDW-1:0] LAST_BAUD = BDW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef OUT_SERIALIZER_PARITY_EN
    PAR,
`endif
    STOP
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BCW-1:0]   bit_q, bit_d;
  logic [BDW-1:0]   baud_q, baud_d;
  logic             tx_q, tx_d;
  logic             baud_end;
`ifdef OUT_SERIALIZER_PARITY_EN
  logic             par_q, par_d;
`endif

  assign baud_end = (baud_q == LAST_BAUD);

  // tx_d is the line level for the state being entered, so the
  // registered tx stays aligned with state_q.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    tx_d    = tx_q;
`ifdef OUT_SERIALIZER_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != IDLE) begin
      baud_d = baud_end ? '0 : baud_q + 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (load) begin
          shift_d = data;
          bit_d   = '0;
          baud_d  = '0;
          state_d = START;
          tx_d    = 1'b0;
`ifdef OUT_SERIALIZER_PARITY_EN
          par_d   = ^data;
`endif
        end
      end
      START: begin
        if (baud_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (baud_end) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == LAST_BIT) begin
`ifdef OUT_SERIALIZER_PARITY_EN
            state_d = PAR;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            tx_d = shift_d[0];
          end
        end
      end
`ifdef OUT_SERIALIZER_PARITY_EN
      PAR: begin
        if (baud_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (baud_end) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      baud_q  <= '0;
      tx_q    <= 1'b1;
`ifdef OUT_SERIALIZER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      tx_q    <= tx_d;
`ifdef OUT_SERIALIZER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx    = tx_q;
  assign ready = (state_q == IDLE);
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == STOP) && baud_end;

endmodule

// File: tb/tb_out_serializer.sv
// tb_out_serializer: randomized + directed bench with frame scoreboard
// and a slot-arithmetic reference model of the serial line.
module tb_out_serializer;

  localparam int W   = 8;
  localparam int CPB = 4;
`ifdef OUT_SERIALIZER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FL = (W + 2 + PB) * CPB;

  logic         clk = 1'b0;
  logic         clear, load;
  logic [W-1:0] data;
  logic         ready, tx, busy, done;

  out_serializer #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .clear(clear), .load(load), .data(data),
    .ready(ready), .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errs    = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: an accepted word owns the FL windows after the
  // accept edge; the port is free again one idle cycle later.
  int           pe = 0;
  int           free_at = 0;
  int           start = -1000000;
  int           accepts = 0;
  bit           started = 0;
  bit           active = 0;
  bit           clr_seen = 0;
  logic [W-1:0] cur_word = '0;
  logic [W-1:0] exp_q[$];

  always @(posedge clk) begin
    pe++;
    if (clear) begin
      started  = 1;
      active   = 0;
      clr_seen = 1;
      free_at  = pe + 1;
      exp_q.delete();
    end else begin
      clr_seen = 0;
      if (started && load && pe >= free_at) begin
        active   = 1;
        start    = pe;
        free_at  = pe + FL + 1;
        cur_word = data;
        accepts++;
        exp_q.push_back(data);
      end
    end
  end

  // Monitor: per-cycle line check plus frame decode popped on done.
  bit   dec_on = 0;
  logic samples[$];

  always @(negedge clk) begin
    int   o, slot;
    bit   inf;
    logic ex;
    logic [W-1:0] got, w;
    if (started) begin
      o   = pe - start;
      inf = active && o >= 0 && o < FL;
      ex  = 1'b1;
      if (inf) begin
        slot = o / CPB;
        if (slot == 0) ex = 1'b0;
        else if (slot <= W) ex = cur_word[slot-1];
        else if (PB == 1 && slot == W + 1) ex = ^cur_word;
      end
      chk("tx", {31'b0, tx}, {31'b0, ex});
      chk("busy", {31'b0, busy}, {31'b0, inf});
      chk("ready", {31'b0, ready}, {31'b0, !inf});
      chk("done", {31'b0, done}, {31'b0, inf && o == FL - 1});

      if (clr_seen) begin
        dec_on = 0;
        samples.delete();
      end
      if (!dec_on && tx === 1'b0) dec_on = 1;
      if (dec_on) samples.push_back(tx);
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          w   = exp_q.pop_front();
          got = '0;
          for (int i = 0; i < W; i++) begin
            if ((1 + i) * CPB + CPB / 2 < samples.size())
              got[i] = samples[(1 + i) * CPB + CPB / 2];
          end
          chk("frame_word", {24'b0, got}, {24'b0, w});
          chk("frame_len", samples.size(), FL);
        end
        dec_on = 0;
        samples.delete();
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (pe < free_at && n < 4 * FL) begin
      tick(1);
      n++;
    end
    if (n >= 4 * FL) chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_accepts(input int k);
    int n = 0;
    while (accepts < k && n < 4 * FL) begin
      tick(1);
      n++;
    end
    if (n >= 4 * FL) chk("wait_accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic send(input logic [W-1:0] d);
    data = d;
    load = 1'b1;
    tick(1);
    load = 1'b0;
  endtask

  initial begin
    int a0;
    clear = 1'b1;
    load  = 1'b0;
    data  = '0;
    tick(2);
    clear = 1'b0;
    tick(3);

    send(8'hA5);
    wait_idle();
    tick(3);

    a0   = accepts;
    data = 8'h00;
    load = 1'b1;
    wait_accepts(a0 + 1);
    data = 8'hFF;
    wait_accepts(a0 + 2);
    load = 1'b0;
    wait_idle();
    tick(3);

    send(8'h81);
    tick(10);
    send(8'h3C);
    data = '0;
    wait_idle();
    tick(3);

    send(8'hF0);
    tick(4 * CPB);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(2);
    send(8'h0F);
    wait_idle();
    tick(3);

    send(8'h07);
    wait_idle();
    send(8'h03);
    wait_idle();
    tick(2);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
      end else begin
        data = W'($urandom);
        load = 1'b1;
        tick($urandom_range(1, FL + 3));
        load = 1'b0;
        data = W'($urandom);
        tick($urandom_range(0, FL));
      end
    end
    wait_idle();
    tick(3);
    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
